flt2int_conv: RTL and testbench

- Float-to-integer converter. It is the reverse-direction companion of the int-to-float program block and uses the same req/ack testbench handshake and the same byte-wide data_mem port.
- On req it does the following:
  - reads a half-precision operand from data memory bytes 4 (MSB) and 5 (LSB);
  - converts it to 16-bit two's complement with round-to-nearest-even and saturation;
  - writes the result to bytes 6 (MSB) and 7 (LSB);
  - raises ack.

---
 rtl/flt2int_conv_if.sv | 31 +++
 rtl/flt2int_conv.sv | 198 +++++++++++++++++++
 tb/tb_flt2int_conv.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/flt2int_conv_if.sv
// Request/acknowledge handshake and byte-wide data memory port of the
// half-precision to int16 converter.
interface flt2int_conv_if;
    logic       req;
    logic       ack;
    logic [7:0] DataAddress;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    modport master (
        output req,
        output DataOut,
        input  ack,
        input  DataAddress,
        input  ReadMem,
        input  WriteMem,
        input  DataIn
    );

    modport slave (
        input  req,
        input  DataOut,
        output ack,
        output DataAddress,
        output ReadMem,
        output WriteMem,
        output DataIn
    );
endinterface

// File: rtl/flt2int_conv.sv
// Converts a half-precision operand held in data memory to a saturated int16
// with round-to-nearest-even, using a bit-serial shifter.
module flt2int_conv #(
    parameter logic [7:0] SRC_ADDR = 8'd4,
    parameter logic [7:0] DST_ADDR = 8'd6
) (
    input  logic           clk,
    input  logic           reset,
    flt2int_conv_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_HI    = 4'd1,
        RD_LO    = 4'd2,
        CLASSIFY = 4'd3,
        SHIFT    = 4'd4,
        ROUND    = 4'd5,
        NEGATE   = 4'd6,
        WR_HI    = 4'd7,
        WR_LO    = 4'd8,
        DONE     = 4'd9
    } state_t;

    state_t      state_r, next_state_s;
    logic [7:0]  op_hi_r, op_lo_r;
    logic [15:0] mag_r, result_r, res_next_s;
    logic        guard_r, sticky_r, left_r;
    logic [4:0]  cnt_r;

    logic        ack_r, rd_r, wr_r;
    logic [7:0]  addr_r, din_r;
    logic        ack_s, rd_s, wr_s;
    logic [7:0]  addr_s, din_s;

    logic        sign_s;
    logic [4:0]  exp_s, cnt_s;
    logic [9:0]  man_s;
    logic        special_s, round_up_s;

    assign sign_s     = op_hi_r[7];
    assign exp_s      = op_hi_r[6:2];
    assign man_s      = {op_hi_r[1:0], op_lo_r};
    // |v| >= 2^15 saturates, |v| < 0.5 always rounds to zero
    assign special_s  = (exp_s >= 5'd30) || (exp_s <= 5'd13);
    assign cnt_s      = (exp_s > 5'd25) ? (exp_s - 5'd25) : (5'd25 - exp_s);
    assign round_up_s = guard_r & (sticky_r | mag_r[0]);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE: next_state_s = bus.req ? RD_HI : state_r;
            RD_HI:      next_state_s = RD_LO;
            RD_LO:      next_state_s = CLASSIFY;
            CLASSIFY: begin
                if (special_s) begin
                    next_state_s = WR_HI;
                end else if (cnt_s == 5'd0) begin
                    next_state_s = ROUND;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            SHIFT:      next_state_s = (cnt_r == 5'd1) ? ROUND : SHIFT;
            ROUND:      next_state_s = NEGATE;
            NEGATE:     next_state_s = WR_HI;
            WR_HI:      next_state_s = WR_LO;
            WR_LO:      next_state_s = DONE;
            default:    next_state_s = IDLE;
        endcase
    end

    // Result value: saturation/zero decided in CLASSIFY, sign applied in NEGATE
    always_comb begin
        res_next_s = result_r;
        if (state_r == CLASSIFY) begin
            if (exp_s >= 5'd30) begin
                res_next_s = sign_s ? 16'h8000 : 16'h7FFF;
            end else if (exp_s <= 5'd13) begin
                res_next_s = 16'h0000;
            end else begin
                res_next_s = result_r;
            end
        end else if (state_r == NEGATE) begin
            res_next_s = sign_s ? (~mag_r + 16'd1) : mag_r;
        end else begin
            res_next_s = result_r;
        end
    end

    // Datapath: operand capture, serial shifter with guard/sticky, rounding
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_hi_r  <= 8'd0;
            op_lo_r  <= 8'd0;
            mag_r    <= 16'd0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            left_r   <= 1'b0;
            cnt_r    <= 5'd0;
            result_r <= 16'd0;
        end else begin
            result_r <= res_next_s;
            case (state_r)
                RD_HI: op_hi_r <= bus.DataOut;
                RD_LO: op_lo_r <= bus.DataOut;
                CLASSIFY: begin
                    mag_r    <= {5'd0, 1'b1, man_s};
                    guard_r  <= 1'b0;
                    sticky_r <= 1'b0;
                    cnt_r    <= cnt_s;
                    left_r   <= (exp_s > 5'd25);
                end
                SHIFT: begin
                    cnt_r <= cnt_r - 5'd1;
                    if (left_r) begin
                        mag_r <= {mag_r[14:0], 1'b0};
                    end else begin
                        mag_r    <= {1'b0, mag_r[15:1]};
                        guard_r  <= mag_r[0];
                        sticky_r <= sticky_r | guard_r;
                    end
                end
                ROUND:   mag_r <= mag_r + {15'd0, round_up_s};
                default: mag_r <= mag_r;
            endcase
        end
    end

    // Bus outputs decoded from the state being entered so they are registered
    always_comb begin
        addr_s = 8'd0;
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        din_s  = 8'd0;
        ack_s  = (state_r == DONE) && (next_state_s == DONE);
        case (next_state_s)
            RD_HI: begin
                addr_s = SRC_ADDR;
                rd_s   = 1'b1;
            end
            RD_LO: begin
                addr_s = SRC_ADDR + 8'd1;
                rd_s   = 1'b1;
            end
            WR_HI: begin
                addr_s = DST_ADDR;
                wr_s   = 1'b1;
                din_s  = res_next_s[15:8];
            end
            WR_LO: begin
                addr_s = DST_ADDR + 8'd1;
                wr_s   = 1'b1;
                din_s  = res_next_s[7:0];
            end
            default: begin
                addr_s = 8'd0;
                rd_s   = 1'b0;
                wr_s   = 1'b0;
                din_s  = 8'd0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_r  <= 1'b0;
            rd_r   <= 1'b0;
            wr_r   <= 1'b0;
            addr_r <= 8'd0;
            din_r  <= 8'd0;
        end else begin
            ack_r  <= ack_s;
            rd_r   <= rd_s;
            wr_r   <= wr_s;
            addr_r <= addr_s;
            din_r  <= din_s;
        end
    end

    assign bus.ack         = ack_r;
    assign bus.ReadMem     = rd_r;
    assign bus.WriteMem    = wr_r;
    assign bus.DataAddress = addr_r;
    assign bus.DataIn      = din_r;

endmodule

// File: tb/tb_flt2int_conv.sv
// Randomized and directed bench for flt2int_conv against an arithmetic
// reference of half-precision to int16 conversion.
module tb_flt2int_conv;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    flt2int_conv_if bus();

    flt2int_conv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] op_hi, op_lo;
    logic [7:0] dmem [0:255];
    int n_vec    = 0;
    int n_err    = 0;
    int wr_cnt   = 0;
    int both_cnt = 0;

    assign bus.DataOut = (bus.DataAddress == 8'd4) ? op_hi :
                         (bus.DataAddress == 8'd5) ? op_lo : dmem[bus.DataAddress];

    // Data memory write port and bus monitors
    always @(posedge clk) begin
        if (bus.WriteMem) begin
            dmem[bus.DataAddress] <= bus.DataIn;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.ReadMem && bus.WriteMem) begin
            both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact value S*2^(E-25), rounded half-to-even, then clamped to int16
    function automatic logic [15:0] ref_conv(input logic [15:0] h);
        int     e;
        int     k;
        longint s, n, q, rem, half, m;
        e = int'(h[14:10]);
        s = longint'({1'b1, h[9:0]});
        if (e == 31) return h[15] ? 16'h8000 : 16'h7FFF;
        if (e >= 25) begin
            n = s << (e - 25);
        end else begin
            k    = 25 - e;
            q    = s >> k;
            rem  = s - (q << k);
            half = 64'sd1 << (k - 1);
            n    = q + (((rem > half) || ((rem == half) && (q % 2 == 1))) ? 64'sd1 : 64'sd0);
        end
        if (!h[15]) begin
            if (n > 32767) return 16'h7FFF;
            return n[15:0];
        end
        if (n > 32768) return 16'h8000;
        m = -n;
        return m[15:0];
    endfunction

    function automatic int ref_lat(input logic [15:0] h);
        int e;
        e = int'(h[14:10]);
        if (e >= 30 || e <= 13) return 6;
        return 8 + ((e > 25) ? (e - 25) : (25 - e));
    endfunction

    // One conversion; optionally pulses req again on cycle glitch_at
    task automatic convert(input logic [15:0] h, input logic [15:0] exp_res,
                           input int exp_lat, input int glitch_at);
        int cyc;
        int w0;
        @(negedge clk);
        op_hi   = h[15:8];
        op_lo   = h[7:0];
        w0      = wr_cnt;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        check("ack_drop", 32'(bus.ack), 32'd0);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            bus.req = (cyc == glitch_at);
        end while (!bus.ack && cyc < 40);
        bus.req = 1'b0;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("result", {16'd0, dmem[6], dmem[7]}, {16'd0, exp_res});
        check("writes", 32'(wr_cnt - w0), 32'd2);
    endtask

    logic [15:0] dir_op  [13] = '{16'h3C00, 16'hC500, 16'h6400, 16'h3800, 16'h3A00,
                                  16'h3E00, 16'h4100, 16'h7800, 16'h7BFF, 16'hF800,
                                  16'h7C00, 16'hFE00, 16'h8000};
    logic [15:0] dir_res [13] = '{16'h0001, 16'hFFFB, 16'h0400, 16'h0000, 16'h0001,
                                  16'h0002, 16'h0002, 16'h7FFF, 16'h7FFF, 16'h8000,
                                  16'h7FFF, 16'h8000, 16'h0000};
    int          dir_lat [13] = '{18, 16, 8, 19, 19, 18, 17, 6, 6, 6, 6, 6, 6};

    initial begin
        logic [15:0] h;
        int          w0;
        reset   = 1'b0;
        bus.req = 1'b0;
        op_hi   = 8'd0;
        op_lo   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_rd", 32'(bus.ReadMem), 32'd0);
        check("rst_wr", 32'(bus.WriteMem), 32'd0);
        check("rst_addr", 32'(bus.DataAddress), 32'd0);
        check("rst_din", 32'(bus.DataIn), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            convert(dir_op[i], dir_res[i], dir_lat[i], 0);
        end

        // Extra req during SHIFT is ignored; ack then holds with req low
        convert(16'h3C00, 16'h0001, 18, 4);
        w0 = wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("ack_hold", 32'(bus.ack), 32'd1);
        check("no_rewrite", 32'(wr_cnt - w0), 32'd0);
        check("hold_res", {16'd0, dmem[6], dmem[7]}, 32'h0000_0001);
        convert(16'hC500, 16'hFFFB, 16, 0);

        // Reset in the middle of SHIFT
        @(negedge clk);
        op_hi   = 8'h41;
        op_lo   = 8'h00;
        w0      = wr_cnt;
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_wr", 32'(bus.WriteMem), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_writes", 32'(wr_cnt - w0), 32'd0);
        check("mid_rst_res", {16'd0, dmem[6], dmem[7]}, 32'h0000_FFFB);
        convert(16'h3A00, 16'h0001, 19, 0);

        for (int i = 0; i < 300; i++) begin
            h = 16'($urandom_range(0, 65535));
            if (i % 2 == 1) h[14:10] = 5'($urandom_range(14, 29));
            convert(h, ref_conv(h), ref_lat(h), 0);
        end

        check("rd_wr_overlap", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
